// File: rtl/sw_result_uart_tx_if.sv
// Result-report port bundle for sw_result_uart_tx: score strobe in, UART line and status out.
interface sw_result_uart_tx_if #(
  parameter int unsigned RESULT_W   = 18,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                i_valid;
  logic [RESULT_W-1:0] i_result;
  logic                o_txd;
  logic                o_busy;
  logic                o_overflow;
  logic [CNT_W-1:0]    o_fifo_count;

  modport master (
    output i_valid, i_result,
    input  o_txd, o_busy, o_overflow, o_fifo_count
  );

  modport slave (
    input  i_valid, i_result,
    output o_txd, o_busy, o_overflow, o_fifo_count
  );
endinterface

// File: rtl/sw_result_uart_tx.sv
// Buffers Smith-Waterman scores and sends each as uppercase hex + CR LF over UART 8N1.
// Define SW_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module sw_result_uart_tx #(
  parameter int unsigned CLK_FREQ   = 30000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned RESULT_W   = 18,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  sw_result_uart_tx_if.slave bus
);

  localparam int unsigned CPB    = CLK_FREQ / BAUD;
  localparam int unsigned BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned ND     = (RESULT_W + 3) / 4;
  localparam int unsigned HEX_W  = ND * 4;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = AW + 1;
  localparam int unsigned CHAR_W = $clog2(ND + 2);

`ifdef SW_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud_cnt, baud_n;
  logic [2:0]          bit_idx, bit_n;
  logic [CHAR_W-1:0]   char_idx, char_n;
  logic [RESULT_W-1:0] word, word_n;
  logic                txd_q, txd_n;
  logic                busy_q;
  logic                overflow_q;
  logic [CNT_W-1:0]    count, count_n;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [RESULT_W-1:0] mem [FIFO_DEPTH];

  logic                pop, push, baud_done;
  logic [HEX_W-1:0]    hex_word;
  logic [3:0]          digit;
  logic [7:0]          cur_char;

  assign baud_done = (baud_cnt == BAUD_W'(CPB - 1));
  assign push      = bus.i_valid && ((count < CNT_W'(FIFO_DEPTH)) || pop);

  // Character currently on the line: hex digit MSD first, then CR, then LF
  always_comb begin
    hex_word = HEX_W'(word);
    digit    = 4'(hex_word >> (4 * (ND - 1 - 32'(char_idx))));
    cur_char = 8'h00;
    if (char_idx == CHAR_W'(ND))          cur_char = 8'h0D;
    else if (char_idx == CHAR_W'(ND + 1)) cur_char = 8'h0A;
    else if (digit < 4'd10)               cur_char = 8'h30 + {4'h0, digit};
    else                                  cur_char = 8'h37 + {4'h0, digit};
  end

  // Next state; txd_n is the line level for the state being entered
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    char_n  = char_idx;
    word_n  = word;
    txd_n   = txd_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          word_n  = mem[rd_ptr];
          char_n  = '0;
          baud_n  = '0;
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          txd_n   = cur_char[0];
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef SW_UART_PARITY_EN
            state_n = PARITY;
            txd_n   = ^cur_char;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
            txd_n = cur_char[3'(bit_idx + 3'd1)];
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
`ifdef SW_UART_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = STOP;
          txd_n   = 1'b1;
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (char_idx < CHAR_W'(ND + 1)) begin
            char_n  = char_idx + CHAR_W'(1);
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      word       <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      char_idx   <= char_n;
      word       <= word_n;
      txd_q      <= txd_n;
      busy_q     <= (state_n != IDLE) || (count_n != '0);
      overflow_q <= overflow_q | (bus.i_valid & ~push);
      count      <= count_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.i_result;
  end

  assign bus.o_txd        = txd_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_fifo_count = count;

endmodule

// File: tb/tb_sw_result_uart_tx.sv
// Scoreboard bench for sw_result_uart_tx: a UART decoder monitor checks every character
// against hand-written expected strings; the main process checks timing and status.
module tb_sw_result_uart_tx;

  localparam int unsigned CLK_FREQ = 2_000_010;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned CPB      = 20;     // 2000010/100000 truncated
  localparam int unsigned RW       = 18;
  localparam int unsigned DEPTH    = 4;
`ifdef SW_UART_PARITY_EN
  localparam int unsigned FRAME    = 11;
`else
  localparam int unsigned FRAME    = 10;
`endif
  localparam int unsigned MSG      = 7 * FRAME * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sw_result_uart_tx_if #(.RESULT_W(RW), .FIFO_DEPTH(DEPTH)) bus ();

  sw_result_uart_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .RESULT_W(RW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_msg(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic strobe(input logic [RW-1:0] v);
    bus.i_valid  = 1'b1;
    bus.i_result = v;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  // UART decoder: samples bit centres, checks each bit is held for a full bit time
  logic       m_act = 1'b0;
  int         m_cnt, m_k, m_ph;
  logic       m_first;
  logic [7:0] m_byte;
  logic [7:0] m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
    end else begin
      if (!m_act && bus.o_txd == 1'b0) begin
        m_act  = 1'b1;
        m_cnt  = 0;
        m_byte = 8'h00;
      end
      if (m_act) begin
        m_k  = m_cnt / CPB;
        m_ph = m_cnt % CPB;
        if (m_ph == 0) m_first = bus.o_txd;
        if (m_ph == CPB / 2) begin
          if (m_k == 0) check("start_bit", 32'(bus.o_txd), 32'd0);
          if (m_k >= 1 && m_k <= 8) m_byte[m_k-1] = bus.o_txd;
`ifdef SW_UART_PARITY_EN
          if (m_k == 9) check("parity_bit", 32'(bus.o_txd), 32'(^m_byte));
`endif
          if (m_k == FRAME - 1) begin
            check("stop_bit", 32'(bus.o_txd), 32'd1);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errs++;
              $display("FAIL unexpected_char: got %02h with nothing expected at %0t", m_byte, $time);
            end else begin
              m_exp = exp_q.pop_front();
              check("char", 32'(m_byte), 32'(m_exp));
            end
            m_act = 1'b0;
          end
        end
        if (m_act && m_ph == CPB - 1) check("bit_hold", 32'(bus.o_txd), 32'(m_first));
        m_cnt++;
      end
    end
  end

  task automatic wait_idle(input int lim);
    int c = 0;
    @(negedge clk);
    while ((bus.o_busy !== 1'b0 || m_act) && c < lim) begin
      @(negedge clk);
      c++;
    end
    check("idle_reached", 32'(c < lim), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int cnt;
    bus.i_valid  = 1'b0;
    bus.i_result = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values and a long idle period
    @(negedge clk);
    check("rst_txd", 32'(bus.o_txd), 32'd1);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("rst_count", 32'(bus.o_fifo_count), 32'd0);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.o_txd !== 1'b1 || bus.o_busy !== 1'b0) bad++;
    end
    check("idle_1000", 32'(bad), 32'd0);
    @(posedge clk);
    #1;

    // Single word: latency, message length
    push_msg("2A5F3");
    strobe(18'h2A5F3);
    @(negedge clk);
    check("txd_after_e0", 32'(bus.o_txd), 32'd1);
    check("count_after_e0", 32'(bus.o_fifo_count), 32'd1);
    check("busy_after_e0", 32'(bus.o_busy), 32'd1);
    @(negedge clk);
    check("txd_fall_e1", 32'(bus.o_txd), 32'd0);
    check("count_after_pop", 32'(bus.o_fifo_count), 32'd0);
    cnt = 0;
    while (bus.o_busy === 1'b1 && cnt < 4 * MSG) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_len", 32'(cnt), 32'(MSG));
    wait_idle(2 * MSG);

    // Two words back to back
    push_msg("00000");
    push_msg("3FFFF");
    strobe(18'h00000);
    strobe(18'h3FFFF);
    @(negedge clk);
    check("b2b_count1", 32'(bus.o_fifo_count), 32'd1);
    check("b2b_txd_start", 32'(bus.o_txd), 32'd0);
    cnt = 0;
    while (bus.o_fifo_count !== '0 && cnt < 4 * MSG) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_gap", 32'(cnt), 32'(MSG + 1));
    check("b2b_second_start", 32'(bus.o_txd), 32'd0);
    wait_idle(3 * MSG);

    // Six strobes: one in flight, four buffered, one dropped
    push_msg("00001");
    push_msg("00002");
    push_msg("00003");
    push_msg("00004");
    push_msg("00005");
    for (int v = 1; v <= 6; v++) strobe(RW'(v));
    @(negedge clk);
    check("ovf_set", 32'(bus.o_overflow), 32'd1);
    check("ovf_count_full", 32'(bus.o_fifo_count), 32'd4);
    wait_idle(7 * MSG);
    check("ovf_sticky", 32'(bus.o_overflow), 32'd1);
    check("ovf_drained", 32'(bus.o_fifo_count), 32'd0);

    // Reset in the data bits of the third character with words still buffered
    push_msg("12345");
    strobe(18'h12345);
    strobe(18'h00001);
    strobe(18'h00002);
    repeat (2 * FRAME * CPB + 4 * CPB - 1) @(posedge clk);
    check("chars_before_reset", 32'(exp_q.size()), 32'd5);
    check("count_before_reset", 32'(bus.o_fifo_count), 32'd2);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_txd", 32'(bus.o_txd), 32'd1);
    check("rst_mid_count", 32'(bus.o_fifo_count), 32'd0);
    check("rst_mid_busy", 32'(bus.o_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ovf_cleared", 32'(bus.o_overflow), 32'd0);
    bad = 0;
    repeat (3 * MSG) begin
      @(negedge clk);
      if (bus.o_txd !== 1'b1 || bus.o_busy !== 1'b0) bad++;
    end
    check("quiet_after_reset", 32'(bad), 32'd0);
    @(posedge clk);
    #1;

    // Small value; with parity enabled the frames carry the parity bit
    push_msg("00007");
    strobe(18'h00007);
    wait_idle(2 * MSG);

    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
